// File: rtl/rtf65002_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rtf65002_mdu_pkg
//  Purpose  : Shared definitions for the RTF65002 multiply/divide unit:
//             operation encodings, the sequencer state enumeration and
//             small opcode-decoding helpers used by the core decoder.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rtf65002_mdu_pkg;

   localparam logic [2:0] OP_MULU = 3'b000;
   localparam logic [2:0] OP_MULS = 3'b001;
   localparam logic [2:0] OP_DIVU = 3'b010;
   localparam logic [2:0] OP_DIVS = 3'b011;
   localparam logic [2:0] OP_MODU = 3'b100;
   localparam logic [2:0] OP_MODS = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_t;

   function automatic logic op_is_mul(input logic [2:0] op);
      return (op == OP_MULU) || (op == OP_MULS);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == OP_DIVU) || (op == OP_DIVS) ||
             (op == OP_MODU) || (op == OP_MODS);
   endfunction

   function automatic logic op_is_legal(input logic [2:0] op);
      return op_is_mul(op) || op_is_div(op);
   endfunction

   // Odd encodings of the legal ops are the signed variants.
   function automatic logic op_is_signed(input logic [2:0] op);
      return op_is_legal(op) && op[0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/rtf65002_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : rtf65002_mdu
//  Purpose  : Sequential multiply / divide unit. Radix-2 shift-add multiply
//             and restoring radix-2 divide on operand magnitudes, one bit per
//             cycle, followed by a sign-fix cycle and a DONE strobe cycle.
//  Params   : WID   operand width (even, >= 8)
//  Ports    : clk    clock, rising edge
//             rst_n  asynchronous active-low reset
//             ld     start pulse, sampled only while idle
//             op     operation select (see package)
//             a, b   multiplicand/dividend, multiplier/divisor
//             busy   high from the cycle after an accepted ld through DONE
//             done   single-cycle completion strobe
//             prod   2*WID product (multiply ops)
//             q, r   quotient / remainder (divide and modulo ops)
//             dbz    divide by zero flag of the last operation
//             ovf    signed divide overflow flag of the last operation
//  Revision : 1.0  initial release
// ============================================================================
module rtf65002_mdu
   import rtf65002_mdu_pkg::*;
#(
   parameter int WID = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic [2:0]       op,
   input  logic [WID-1:0]   a,
   input  logic [WID-1:0]   b,
   output logic             busy,
   output logic             done,
   output logic [2*WID-1:0] prod,
   output logic [WID-1:0]   q,
   output logic [WID-1:0]   r,
   output logic             dbz,
   output logic             ovf
);

   localparam int             CW       = $clog2(WID) + 1;
   localparam logic [WID-1:0] MOST_NEG = {1'b1, {(WID-1){1'b0}}};
   localparam logic [2*WID-1:0] ONE2   = {{(2*WID-1){1'b0}}, 1'b1};

   // Conditional two's-complement negation; narrower values are passed
   // zero-extended and only the low half of the result is used.
   function automatic logic [2*WID-1:0] cneg(input logic [2*WID-1:0] x,
                                             input logic             en);
      return en ? (~x + ONE2) : x;
   endfunction

   mdu_state_t       state, state_nxt;
   logic [2:0]       op_r;
   logic [2*WID-1:0] sr;          // {acc/remainder, multiplier/dividend->quotient}
   logic [WID-1:0]   mag_b;
   logic [CW-1:0]    cnt;
   logic             neg_q;       // negate product / quotient in FIX
   logic             neg_r;       // negate remainder in FIX
   logic             dbz_p;
   logic             ovf_p;
   logic             ill_p;

   logic             start;
   logic             sgn_in;
   logic             div_in;
   logic             b_zero;
   logic             last_iter;
   logic [2*WID-1:0] a_cond;
   logic [2*WID-1:0] b_cond;
   logic [WID:0]     mul_sum;
   logic [WID:0]     div_hi;
   logic [WID:0]     div_diff;
   logic             div_ge;
   logic [2*WID-1:0] prod_fix;
   logic [2*WID-1:0] q_fix;
   logic [2*WID-1:0] r_fix;
   logic             unused_bits;

   assign start     = (state == ST_IDLE) && ld;
   assign sgn_in    = op_is_signed(op);
   assign div_in    = op_is_div(op);
   assign b_zero    = (b == '0);
   assign last_iter = (cnt == CW'(WID - 1));

   // Operand magnitudes; the most-negative value maps to 2**(WID-1),
   // which still fits as an unsigned WID-bit magnitude.
   assign a_cond = cneg({{WID{1'b0}}, a}, sgn_in & a[WID-1]);
   assign b_cond = cneg({{WID{1'b0}}, b}, sgn_in & b[WID-1]);

   // Shift-add step: add multiplicand when the current multiplier bit is
   // set, then shift the whole register right including the carry-out.
   assign mul_sum = {1'b0, sr[2*WID-1:WID]} + (sr[0] ? {1'b0, mag_b} : '0);

   // Restoring step: partial remainder shifted left by one with the next
   // dividend bit. It is always below 2*mag_b, so a successful subtract
   // leaves a value that fits in WID bits.
   assign div_hi   = sr[2*WID-1:WID-1];
   assign div_ge   = (div_hi >= {1'b0, mag_b});
   assign div_diff = div_hi - {1'b0, mag_b};

   assign prod_fix = cneg(sr, neg_q);
   assign q_fix    = cneg({{WID{1'b0}}, sr[WID-1:0]}, neg_q);
   assign r_fix    = cneg({{WID{1'b0}}, sr[2*WID-1:WID]}, neg_r);

   assign unused_bits = ^{a_cond[2*WID-1:WID], b_cond[2*WID-1:WID],
                          q_fix[2*WID-1:WID], r_fix[2*WID-1:WID], div_diff[WID]};

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ld) begin
               if (!op_is_legal(op) || (div_in && b_zero)) state_nxt = ST_FIX;
               else if (op_is_mul(op))                     state_nxt = ST_MUL;
               else                                        state_nxt = ST_DIV;
            end
         end
         ST_MUL:  if (last_iter) state_nxt = ST_FIX;
         ST_DIV:  if (last_iter) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r  <= '0;
         sr    <= '0;
         mag_b <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dbz_p <= 1'b0;
         ovf_p <= 1'b0;
         ill_p <= 1'b0;
      end else if (start) begin
         op_r  <= op;
         mag_b <= b_cond[WID-1:0];
         cnt   <= '0;
         neg_q <= sgn_in & (a[WID-1] ^ b[WID-1]);
         neg_r <= sgn_in & a[WID-1];
         dbz_p <= div_in & b_zero;
         ovf_p <= sgn_in & div_in & (a == MOST_NEG) & (b == '1);
         ill_p <= !op_is_legal(op);
         // On divide by zero the raw dividend is parked for the remainder.
         sr    <= (div_in && b_zero) ? {{WID{1'b0}}, a}
                                     : {{WID{1'b0}}, a_cond[WID-1:0]};
      end else if (state == ST_MUL) begin
         sr  <= {mul_sum, sr[WID-1:1]};
         cnt <= cnt + 1'b1;
      end else if (state == ST_DIV) begin
         sr  <= div_ge ? {div_diff[WID-1:0], sr[WID-2:0], 1'b1}
                       : {div_hi[WID-1:0],   sr[WID-2:0], 1'b0};
         cnt <= cnt + 1'b1;
      end
   end

   // Result registers load on the FIX->DONE edge, so they change exactly
   // as done rises and then hold until the next operation completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
         q    <= '0;
         r    <= '0;
         dbz  <= 1'b0;
         ovf  <= 1'b0;
      end else if (state == ST_FIX) begin
         prod <= '0;
         q    <= '0;
         r    <= '0;
         dbz  <= 1'b0;
         ovf  <= 1'b0;
         if (!ill_p) begin
            if (op_is_mul(op_r)) begin
               prod <= prod_fix;
            end else if (dbz_p) begin
               q   <= '1;
               r   <= sr[WID-1:0];
               dbz <= 1'b1;
            end else begin
               q   <= q_fix[WID-1:0];
               r   <= r_fix[WID-1:0];
               ovf <= ovf_p;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rtf65002_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtf65002_mdu
//  Purpose  : Self-checking bench for rtf65002_mdu at WID=32 and WID=8.
//             A behavioural model computes results from integer arithmetic;
//             one compare process checks busy/done/results every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtf65002_mdu;
   import rtf65002_mdu_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        ld32 = 1'b0, ld8 = 1'b0;
   logic [2:0]  op32 = '0,   op8 = '0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [7:0]  a8 = '0,  b8 = '0;
   logic        busy32, done32, dbz32, ovf32;
   logic [63:0] prod32;
   logic [31:0] q32, r32;
   logic        busy8, done8, dbz8, ovf8;
   logic [15:0] prod8;
   logic [7:0]  q8, r8;

   rtf65002_mdu #(.WID(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .ld(ld32), .op(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .prod(prod32), .q(q32), .r(r32),
      .dbz(dbz32), .ovf(ovf32));

   rtf65002_mdu #(.WID(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .ld(ld8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .prod(prod8), .q(q8), .r(r8),
      .dbz(dbz8), .ovf(ovf8));

   typedef struct {
      int          ld_cyc;
      int          lat;
      logic [63:0] prod;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   exp_t        expq[2][$];
   logic [63:0] hprod[2];
   logic [31:0] hq[2];
   logic [31:0] hr[2];
   logic        hdbz[2];
   logic        hovf[2];
   int          vecs  = 0;
   int          fails = 0;
   int          cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------------
   // Reference model: plain integer arithmetic, truncating division
   // ------------------------------------------------------------------
   function automatic exp_t model(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t               e;
      logic [63:0]        m, pm, ua, ub;
      longint             sa, sb, qq, rr;
      logic signed [127:0] x, y, p;
      m  = (64'd1 << w) - 64'd1;
      pm = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
      ua = {32'd0, a} & m;
      ub = {32'd0, b} & m;
      sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
      sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
      e.ld_cyc = 0;
      e.lat  = w + 2;
      e.prod = '0; e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0;
      case (op)
         OP_MULU: begin x = ua; y = ub; p = x * y; e.prod = p[63:0] & pm; end
         OP_MULS: begin x = sa; y = sb; p = x * y; e.prod = p[63:0] & pm; end
         OP_DIVU, OP_MODU: begin
            if (ub == 0) begin
               e.q = m[31:0]; e.r = ua[31:0]; e.dbz = 1'b1; e.lat = 2;
            end else begin
               e.q = 32'(ua / ub); e.r = 32'(ua % ub);
            end
         end
         OP_DIVS, OP_MODS: begin
            if (sb == 0) begin
               e.q = m[31:0]; e.r = ua[31:0]; e.dbz = 1'b1; e.lat = 2;
            end else begin
               qq = sa / sb; rr = sa % sb;
               e.q = 32'(qq) & m[31:0];
               e.r = 32'(rr) & m[31:0];
               e.ovf = (sa == -(longint'(1) << (w-1))) && (sb == -1);
            end
         end
         default: e.lat = 2;
      endcase
      return e;
   endfunction

   task automatic cmp(input string nm, input int i, input logic [63:0] act,
                      input logic [63:0] want);
      vecs++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s w%0d cyc=%0d got=%h want=%h", nm, (i == 0) ? 32 : 8,
                  cyc, act, want);
      end
   endtask

   // ------------------------------------------------------------------
   // Compare process
   // ------------------------------------------------------------------
   task automatic check(input int i);
      logic [63:0] p;
      logic [31:0] qq, rr;
      logic        bz, dn, dz, of, bexp, due;
      exp_t        e;
      if (i == 0) begin
         p = prod32; qq = q32; rr = r32; bz = busy32; dn = done32; dz = dbz32; of = ovf32;
      end else begin
         p = {48'd0, prod8}; qq = {24'd0, q8}; rr = {24'd0, r8};
         bz = busy8; dn = done8; dz = dbz8; of = ovf8;
      end
      if (!rst_n) begin
         cmp("rst_busy", i, {63'd0, bz}, 64'd0);
         cmp("rst_done", i, {63'd0, dn}, 64'd0);
         cmp("rst_res",  i, p | {32'd0, qq | rr} | {62'd0, dz, of}, 64'd0);
         return;
      end
      bexp = (expq[i].size() > 0) && (cyc > expq[i][0].ld_cyc);
      due  = (expq[i].size() > 0) && (cyc == expq[i][0].ld_cyc + expq[i][0].lat);
      cmp("busy", i, {63'd0, bz}, {63'd0, bexp});
      cmp("done", i, {63'd0, dn}, {63'd0, due});
      if (due) begin
         e = expq[i].pop_front();
         hprod[i] = e.prod; hq[i] = e.q; hr[i] = e.r; hdbz[i] = e.dbz; hovf[i] = e.ovf;
      end
      cmp("prod", i, p, hprod[i]);
      cmp("q",    i, {32'd0, qq}, {32'd0, hq[i]});
      cmp("r",    i, {32'd0, rr}, {32'd0, hr[i]});
      cmp("dbz",  i, {63'd0, dz}, {63'd0, hdbz[i]});
      cmp("ovf",  i, {63'd0, of}, {63'd0, hovf[i]});
   endtask

   always @(negedge clk) begin
      check(0);
      check(1);
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic clear_held();
      for (int i = 0; i < 2; i++) begin
         expq[i].delete();
         hprod[i] = '0; hq[i] = '0; hr[i] = '0; hdbz[i] = 1'b0; hovf[i] = 1'b0;
      end
   endtask

   task automatic issue(input int i, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(posedge clk); #2;
      if (i == 0) begin ld32 = 1'b1; op32 = op; a32 = a; b32 = b; end
      else        begin ld8  = 1'b1; op8  = op; a8  = a[7:0]; b8 = b[7:0]; end
      e = model((i == 0) ? 32 : 8, op, a, b);
      e.ld_cyc = cyc;
      expq[i].push_back(e);
      @(posedge clk); #2;
      // Scramble inputs while busy: the latched copies must be used.
      if (i == 0) begin ld32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom; end
      else        begin ld8  = 1'b0; op8  = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      while (expq[i].size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (expq[i].size() > 0) begin
         vecs++; fails++;
         $display("FAIL timeout w%0d cyc=%0d got=no_done want=done", (i == 0) ? 32 : 8, cyc);
         expq[i].delete();
      end
   endtask

   task automatic run(input int i, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
      issue(i, op, a, b);
      wait_idle(i);
   endtask

   function automatic logic [31:0] pick(input int w);
      logic [31:0] m;
      m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return m;
         3:       return 32'd1 << (w - 1);
         4:       return m >> 1;
         5:       return 32'd2;
         default: return $urandom & m;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      exp_t e;
      clear_held();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Hand-computed values pinning the model
      e = model(32, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cmp("pin_mulu", 0, e.prod, 64'hFFFF_FFFE_0000_0001);
      cmp("pin_mulu_lat", 0, 64'(e.lat), 64'd34);
      e = model(32, OP_MULS, 32'h8000_0000, 32'h8000_0000);
      cmp("pin_muls_neg", 0, e.prod, 64'h4000_0000_0000_0000);
      e = model(32, OP_MULS, 32'hFFFF_FFFF, 32'h0000_0003);
      cmp("pin_muls", 0, e.prod, 64'hFFFF_FFFF_FFFF_FFFD);
      e = model(32, OP_DIVS, 32'hFFFF_FFF9, 32'h0000_0002);
      cmp("pin_divs", 0, {e.q, e.r}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      e = model(32, OP_DIVU, 32'd7, 32'd2);
      cmp("pin_divu", 0, {e.q, e.r}, {32'd3, 32'd1});
      e = model(32, OP_DIVU, 32'h1234_5678, 32'd0);
      cmp("pin_dbz", 0, {e.q, e.r}, {32'hFFFF_FFFF, 32'h1234_5678});
      cmp("pin_dbz_flag", 0, {62'd0, e.dbz, e.ovf}, 64'd2);
      cmp("pin_dbz_lat", 0, 64'(e.lat), 64'd2);
      e = model(32, OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
      cmp("pin_ovf", 0, {e.q, e.r}, {32'h8000_0000, 32'd0});
      cmp("pin_ovf_flag", 0, {63'd0, e.ovf}, 64'd1);
      e = model(8, OP_MODS, 32'h0000_00F9, 32'h0000_0002);
      cmp("pin_mods8", 1, {32'd0, e.r}, 64'h0000_00FF);

      // Directed cases on both widths
      run(0, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(0, OP_MULS, 32'h8000_0000, 32'h8000_0000);
      run(0, OP_MULS, 32'hFFFF_FFFF, 32'h0000_0003);
      run(0, OP_DIVS, 32'hFFFF_FFF9, 32'h0000_0002);
      run(0, OP_DIVU, 32'd7, 32'd2);
      run(0, OP_DIVU, 32'h1234_5678, 32'd0);
      run(0, OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
      run(0, OP_MODS, 32'h8000_0000, 32'hFFFF_FFFF);
      run(0, OP_MODS, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      run(0, 3'b110, 32'h1234_5678, 32'h9ABC_DEF0);
      run(0, 3'b111, 32'hFFFF_FFFF, 32'd0);
      run(1, OP_MULS, 32'h80, 32'h80);
      run(1, OP_MULU, 32'hFF, 32'hFF);
      run(1, OP_DIVS, 32'h80, 32'hFF);
      run(1, OP_MODU, 32'h5A, 32'd0);
      run(1, OP_DIVS, 32'h7F, 32'h80);

      // A second ld while busy must be ignored
      issue(0, OP_MULU, 32'h0001_2345, 32'h0000_0100);
      repeat (3) @(posedge clk);
      #2 ld32 = 1'b1; op32 = OP_DIVU; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0003;
      @(posedge clk);
      #2 ld32 = 1'b0;
      wait_idle(0);

      // Reset mid-operation: busy drops at once, no done, outputs cleared
      issue(0, OP_MULU, 32'hDEAD_BEEF, 32'h1234_5678);
      issue(1, OP_DIVU, 32'h0000_00C8, 32'h0000_0007);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      clear_held();
      #1;
      cmp("rst_async_busy", 0, {63'd0, busy32}, 64'd0);
      cmp("rst_async_done", 0, {63'd0, done32}, 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(0, OP_DIVS, 32'hFFFF_FF9C, 32'h0000_0007);
      run(1, OP_MULS, 32'h0000_0081, 32'h0000_007F);

      // Randomized regression
      for (int k = 0; k < 250; k++)
         run(0, 3'($urandom_range(0, 7)), pick(32), pick(32));
      for (int k = 0; k < 400; k++)
         run(1, 3'($urandom_range(0, 7)), pick(8), pick(8));

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
`default_nettype wire
